// File: rtl/sc_player_fsm_if.sv
// Button/position bundle between the debounced inputs, the player FSM and the playfield.
// Widths follow the COLS/ROWS of the attached sc_player_fsm instance.
interface sc_player_fsm_if #(
    parameter int COLS = 8,
    parameter int ROWS = 8
);
    localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

    logic          sc_player_fsm_Start_InLow;
    logic          sc_player_fsm_upButton_InLow;
    logic          sc_player_fsm_downButton_InLow;
    logic          sc_player_fsm_leftButton_InLow;
    logic          sc_player_fsm_rightButton_InLow;
    logic          sc_player_fsm_Freeze_InHigh;
    logic [CW-1:0] sc_player_fsm_col_Out;
    logic [RW-1:0] sc_player_fsm_row_Out;
    logic [1:0]    sc_player_fsm_dir_Out;
    logic          sc_player_fsm_moved_OutHigh;
    logic          sc_player_fsm_clear_OutLow;
    logic          sc_player_fsm_goal_OutHigh;

    modport master (
        output sc_player_fsm_Start_InLow,
        output sc_player_fsm_upButton_InLow,
        output sc_player_fsm_downButton_InLow,
        output sc_player_fsm_leftButton_InLow,
        output sc_player_fsm_rightButton_InLow,
        output sc_player_fsm_Freeze_InHigh,
        input  sc_player_fsm_col_Out,
        input  sc_player_fsm_row_Out,
        input  sc_player_fsm_dir_Out,
        input  sc_player_fsm_moved_OutHigh,
        input  sc_player_fsm_clear_OutLow,
        input  sc_player_fsm_goal_OutHigh
    );

    modport slave (
        input  sc_player_fsm_Start_InLow,
        input  sc_player_fsm_upButton_InLow,
        input  sc_player_fsm_downButton_InLow,
        input  sc_player_fsm_leftButton_InLow,
        input  sc_player_fsm_rightButton_InLow,
        input  sc_player_fsm_Freeze_InHigh,
        output sc_player_fsm_col_Out,
        output sc_player_fsm_row_Out,
        output sc_player_fsm_dir_Out,
        output sc_player_fsm_moved_OutHigh,
        output sc_player_fsm_clear_OutLow,
        output sc_player_fsm_goal_OutHigh
    );
endinterface

// File: rtl/sc_player_fsm.sv
// Frogger player-position FSM: one bounded move per button press, start/goal handling.
// Optional auto-repeat of a held direction when SC_PLAYER_FSM_AUTOREPEAT_EN is defined.
module sc_player_fsm #(
    parameter int COLS        = 8,
    parameter int ROWS        = 8,
    parameter int START_COL   = COLS / 2,
    parameter int START_ROW   = 0,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic           sc_player_fsm_CLOCK_50,
    input  logic           sc_player_fsm_RESET_InHigh,
    sc_player_fsm_if.slave bus
);
    localparam int CW = (COLS > 2) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 2) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] COL_MAX   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_TOP   = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_START = CW'(START_COL);
    localparam logic [RW-1:0] ROW_START = RW'(START_ROW);

    typedef enum logic [3:0] {
        S_RESET,
        S_IDLE,
        S_CHECK,
        S_INIT,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_MOVE_LEFT,
        S_MOVE_RIGHT,
        S_GOAL,
        S_RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [1:0]    dir_q, dir_d;

    logic start_n, up_n, down_n, left_n, right_n, freeze;
    logic up_ok, down_ok, left_ok, right_ok;
    logic all_rel, rep_go;

    assign start_n = bus.sc_player_fsm_Start_InLow;
    assign up_n    = bus.sc_player_fsm_upButton_InLow;
    assign down_n  = bus.sc_player_fsm_downButton_InLow;
    assign left_n  = bus.sc_player_fsm_leftButton_InLow;
    assign right_n = bus.sc_player_fsm_rightButton_InLow;
    assign freeze  = bus.sc_player_fsm_Freeze_InHigh;

    // An out-of-bounds or frozen direction counts as not pressed.
    assign up_ok    = !up_n    && !freeze && (row_q < ROW_TOP);
    assign down_ok  = !down_n  && !freeze && (row_q > '0);
    assign left_ok  = !left_n  && !freeze && (col_q > '0);
    assign right_ok = !right_n && !freeze && (col_q < COL_MAX);

    assign all_rel = start_n & up_n & down_n & left_n & right_n;

`ifdef SC_PLAYER_FSM_AUTOREPEAT_EN
    localparam int HCW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] CNT_LAST = HCW'(HOLD_CYCLES - 1);

    logic [HCW-1:0] cnt_q, cnt_d;
    logic           held;

    always_comb begin
        held = 1'b0;
        unique case (dir_q)
            2'b00:   held = !up_n;
            2'b01:   held = !down_n;
            2'b10:   held = !left_n;
            default: held = !right_n;
        endcase
    end

    assign rep_go = held && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = '0;
        if (state_q == S_RELEASE && state_d == S_RELEASE && held)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge sc_player_fsm_CLOCK_50 or posedge sc_player_fsm_RESET_InHigh) begin
        if (sc_player_fsm_RESET_InHigh)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
`else
    logic unused_hold;
    assign unused_hold = |HOLD_CYCLES;
    assign rep_go      = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dir_d   = dir_q;
        unique case (state_q)
            S_RESET: state_d = S_IDLE;
            S_IDLE: begin
                if (!start_n) begin
                    state_d = S_INIT;
                    col_d   = COL_START;
                    row_d   = ROW_START;
                end
            end
            S_CHECK: begin
                if (!start_n) begin
                    state_d = S_INIT;
                    col_d   = COL_START;
                    row_d   = ROW_START;
                end else if (up_ok) begin
                    state_d = S_MOVE_UP;
                    row_d   = row_q + 1'b1;
                    dir_d   = 2'b00;
                end else if (down_ok) begin
                    state_d = S_MOVE_DOWN;
                    row_d   = row_q - 1'b1;
                    dir_d   = 2'b01;
                end else if (left_ok) begin
                    state_d = S_MOVE_LEFT;
                    col_d   = col_q - 1'b1;
                    dir_d   = 2'b10;
                end else if (right_ok) begin
                    state_d = S_MOVE_RIGHT;
                    col_d   = col_q + 1'b1;
                    dir_d   = 2'b11;
                end
            end
            S_INIT: state_d = S_RELEASE;
            S_MOVE_UP: state_d = (row_q == ROW_TOP) ? S_GOAL : S_RELEASE;
            S_MOVE_DOWN,
            S_MOVE_LEFT,
            S_MOVE_RIGHT: state_d = S_RELEASE;
            S_GOAL: begin
                state_d = S_RELEASE;
                col_d   = COL_START;
                row_d   = ROW_START;
            end
            S_RELEASE: begin
                if (all_rel || rep_go)
                    state_d = S_CHECK;
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge sc_player_fsm_CLOCK_50 or posedge sc_player_fsm_RESET_InHigh) begin
        if (sc_player_fsm_RESET_InHigh) begin
            state_q <= S_RESET;
            col_q   <= COL_START;
            row_q   <= ROW_START;
            dir_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.sc_player_fsm_col_Out      = col_q;
    assign bus.sc_player_fsm_row_Out      = row_q;
    assign bus.sc_player_fsm_dir_Out      = dir_q;
    assign bus.sc_player_fsm_clear_OutLow = (state_q != S_INIT);
    assign bus.sc_player_fsm_goal_OutHigh = (state_q == S_GOAL);
    assign bus.sc_player_fsm_moved_OutHigh =
        (state_q == S_MOVE_UP)   || (state_q == S_MOVE_DOWN) ||
        (state_q == S_MOVE_LEFT) || (state_q == S_MOVE_RIGHT);
endmodule
